// File: rtl/hilo_muldiv_controller.sv
// hilo_muldiv_controller: HI/LO multiply/divide sequencer with pipelined multiply,
// 32-step restoring divide and stall generation for hazard logic.
module hilo_muldiv_controller #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  ex_op,
  input  logic        ex_flush,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  input  logic        id_reads_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall_req
);
  localparam int DIV_STEPS = 32;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
  logic        op_valid, is_mul, is_div, is_signed, start, borrow;
  logic [31:0] rs_abs, rt_abs, quo_fix, rem_fix;
  logic [32:0] sh;
  logic [63:0] prod;
  assign op_valid  = ex_op >= 3'd1 && ex_op <= 3'd6;
  assign is_mul    = ex_op == 3'd1 || ex_op == 3'd2;
  assign is_div    = ex_op == 3'd3 || ex_op == 3'd4;
  assign is_signed = ex_op == 3'd1 || ex_op == 3'd3;
  assign busy      = state_q != IDLE;
  assign start     = op_valid & ~busy & ~ex_flush;
  assign stall_req = (busy & op_valid) | (id_reads_hilo & (busy | (start & (is_mul | is_div))));
  assign rs_abs    = (ex_op == 3'd3 && ex_rs_data[31]) ? -ex_rs_data : ex_rs_data;
  assign rt_abs    = (ex_op == 3'd3 && ex_rt_data[31]) ? -ex_rt_data : ex_rt_data;
  // Sign-extended 64x64 product keeps the low 64 bits correct for both signednesses
  assign prod    = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
  assign sh      = {rem_q, a_q[31]};
  assign borrow  = sh < {1'b0, b_q};
  assign quo_fix = qneg_q ? -a_q : a_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign done    = done_q;
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        hi_d    = ex_op == 3'd5 ? ex_rs_data : hi_q;
        lo_d    = ex_op == 3'd6 ? ex_rs_data : lo_q;
        a_d     = is_div ? rs_abs : ex_rs_data;
        b_d     = is_div ? rt_abs : ex_rt_data;
        sgn_d   = is_signed;
        qneg_d  = ex_op == 3'd3 && (ex_rs_data[31] ^ ex_rt_data[31]);
        rneg_d  = ex_op == 3'd3 && ex_rs_data[31];
        rem_d   = '0;
        cnt_d   = '0;
        state_d = is_mul ? MUL : is_div ? DIV : IDLE;
      end
      MUL: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_LATENCY - 1)) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      DIV: begin
        rem_d   = borrow ? sh[31:0] : 32'(sh - {1'b0, b_q});
        a_d     = {a_q[30:0], ~borrow};
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'(DIV_STEPS - 1) ? FIX : DIV;
      end
      FIX: begin
        lo_d    = quo_fix;
        hi_d    = rem_fix;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// tb_hilo_muldiv_controller: scoreboard bench; driver pushes expected HI/LO results,
// monitor pops them on done and tracks architectural HI/LO every cycle.
module tb_hilo_muldiv_controller;
  localparam int ML = 2;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic [2:0]  ex_op = '0;
  logic        ex_flush = 1'b0, id_reads_hilo = 1'b0;
  logic [31:0] ex_rs_data = '0, ex_rt_data = '0;
  logic [31:0] hi, lo;
  logic        busy, done, stall_req;
  int errors = 0, checks = 0;
  typedef struct {bit is_hi; logic [31:0] v;} mt_t;
  logic [63:0] exp_q[$];
  mt_t         mt_q[$];
  mt_t         m;
  logic [31:0] arch_hi = '0, arch_lo = '0;

  hilo_muldiv_controller #(.MUL_LATENCY(ML)) dut (
    .clock(clock), .reset_n(reset_n), .ex_op(ex_op), .ex_flush(ex_flush),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .id_reads_hilo(id_reads_hilo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int a, b;
    a = int'(rs);
    b = int'(rt);
    case (op)
      3'd1: return longint'(a) * longint'(b);
      3'd2: return {32'd0, rs} * {32'd0, rt};
      3'd3: begin
        if (rt == 0) return {rs, rs[31] ? 32'd1 : 32'hFFFFFFFF};
        if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(a % b), 32'(a / b)};
      end
      3'd4: return rt == 0 ? {rs, 32'hFFFFFFFF} : {rs % rt, rs / rt};
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      mt_q.delete();
      arch_hi = '0;
      arch_lo = '0;
    end else begin
      while (mt_q.size() > 0) begin
        m = mt_q.pop_front();
        if (m.is_hi) arch_hi = m.v;
        else arch_lo = m.v;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=1 want no pulse (nothing pending)");
        end else {arch_hi, arch_lo} = exp_q.pop_front();
      end
      check("hi", hi, arch_hi);
      check("lo", lo, arch_lo);
    end
  end

  // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input bit idr, input bit flush, input logic [2:0] follow,
                        input logic [31:0] fv, input bit fl_busy);
    bit md, mv;
    int lat;
    md = op >= 3'd1 && op <= 3'd4;
    mv = op >= 3'd1 && op <= 3'd6;
    lat = op <= 3'd2 ? ML : 33;
    ex_op = op;
    ex_rs_data = rs;
    ex_rt_data = rt;
    id_reads_hilo = idr;
    ex_flush = flush;
    @(negedge clock);
    check("stall_idle", stall_req, idr & md & !flush);
    @(posedge clock);
    #1;
    if (!mv || flush) begin
      ex_op = '0;
      ex_flush = 1'b0;
      id_reads_hilo = 1'b0;
      @(negedge clock);
      check("busy_not_started", busy, 0);
      @(posedge clock);
      #1;
      return;
    end
    if (!md) begin
      mt_q.push_back('{op == 3'd5, rs});
      ex_op = '0;
      id_reads_hilo = 1'b0;
      return;
    end
    exp_q.push_back(ref_op(op, rs, rt));
    ex_op = follow;
    ex_rs_data = fv;
    for (int k = 1; k <= lat; k++) begin
      ex_flush = fl_busy & ($urandom_range(0, 1) == 1);
      @(negedge clock);
      check("busy_inflight", busy, 1);
      check("done_inflight", done, 0);
      check("stall_inflight", stall_req, idr | (follow != 3'd0));
      @(posedge clock);
      #1;
    end
    ex_flush = 1'b0;
    @(negedge clock);
    check("busy_after", busy, 0);
    check("done_pulse", done, 1);
    check("stall_after", stall_req, 0);
    @(posedge clock);
    #1;
    if (follow == 3'd5 || follow == 3'd6) mt_q.push_back('{follow == 3'd5, fv});
    ex_op = '0;
    id_reads_hilo = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_op(3'd1, 32'hFFFFFFFB, 32'd3, 1, 0, 3'd0, 0, 0);
    run_op(3'd4, 32'd100, 32'd7, 0, 0, 3'd0, 0, 0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 3'd0, 0, 0);
    run_op(3'd4, 32'h1234, 32'd0, 0, 0, 3'd0, 0, 0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 3'd0, 0, 0);
    run_op(3'd3, 32'hFFFFFF00, 32'd0, 0, 0, 3'd0, 0, 0);
    run_op(3'd6, 32'hABCD, 32'd0, 1, 0, 3'd0, 0, 0);
    run_op(3'd3, 32'd12345, 32'd67, 0, 0, 3'd5, 32'hCAFEF00D, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 3'd6, 32'h5A5A5A5A, 1);
    run_op(3'd1, 32'd5, 32'd5, 1, 1, 3'd0, 0, 0);
    run_op(3'd5, 32'h11111111, 32'd0, 0, 1, 3'd0, 0, 0);
    run_op(3'd3, 32'h7FFFFFFF, 32'hFFFFFFFD, 1, 0, 3'd0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] fo;
      fo = $urandom_range(0, 2) == 0 ? 3'd0 : 3'(4 + $urandom_range(1, 2));
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0, fo, $urandom, $urandom_range(0, 1) == 1);
    end
    // Reset in the middle of a divide
    run_op(3'd4, 32'hDEADBEEF, 32'd3, 0, 0, 3'd0, 0, 0);
    ex_op = 3'd3;
    ex_rs_data = 32'd1000;
    ex_rt_data = 32'd7;
    @(posedge clock);
    #1;
    ex_op = '0;
    repeat (10) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_op(3'd1, 32'd6, 32'd7, 0, 0, 3'd0, 0, 0);
    check("post_reset_lo", lo, 42);
    check("post_reset_hi", hi, 0);
    repeat (3) @(posedge clock);
    #1;
    check("pending_results", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_controller.md
Name: hilo_muldiv_controller

Overview:
- Sequences the HI/LO multiply/divide resource for the pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Runs a pipelined multiply or an iterative 32-step restoring divide, then writes the HI/LO registers.
- Raises a stall request to the hazard logic when a following instruction needs HI/LO, or the resource, while it is busy.

Parameters:
MUL_LATENCY, 2, edges from accepted multiply to HI/LO write; legal range 1..4.
DIV_STEPS, 32, restoring-divide iterations; fixed at 32, not for override.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
ex_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
ex_flush  input  1  EX instruction is being squashed; suppresses start
ex_rs_data  input  32  forwarded rs operand (dividend / multiplicand / MT source)
ex_rt_data  input  32  forwarded rt operand (divisor / multiplier)
id_reads_hilo  input  1  instruction in ID is MFHI or MFLO
hi  output  32  architectural HI
lo  output  32  architectural LO
busy  output  1  operation in flight (state != IDLE)
done  output  1  one-cycle pulse on the cycle after HI/LO are written by MUL/DIV
stall_req  output  1  to hazard unit; freezes IF/ID/EX

Behaviour:
- Reset (async, reset_n low): state IDLE; hi, lo, counters and operand registers = 0; busy = 0; done = 0.
  - Reset mid-operation aborts the operation; HI/LO are left at 0.
- start = (ex_op in 1..6) & !busy & !ex_flush. The operation is accepted at the rising edge where start = 1 (edge T).
- MTHI/MTLO:
  - hi (resp. lo) <= ex_rs_data at edge T.
  - State stays IDLE; done is not pulsed.
- MULT/MULTU:
  - At edge T the operands are captured and state goes to MUL.
  - {hi,lo} <= the 64-bit product (signed or unsigned) at edge T+MUL_LATENCY; state then returns to IDLE.
  - An internal register or pipeline of the product is permitted.
- DIV/DIVU:
  - At edge T: capture |rs|, |rt| (the raw values for DIVU) and the sign flags; iteration count = 0; state goes to DIV.
  - Each DIV edge performs one restoring step. After DIV_STEPS edges, state goes to FIX.
  - At the FIX edge (T+33): sign correction is applied, then lo <= quotient, hi <= remainder, and state goes to IDLE.
  - Signed rules: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Divide by zero: no trap; completes with normal timing. lo = 32'hFFFFFFFF for DIVU; for DIV, lo = 32'hFFFFFFFF if rs >= 0, else 32'h00000001. hi = rs in both cases.
  - 0x80000000 / -1 (DIV): lo = 0x80000000, hi = 0.
- busy:
  - Multiply: high from the cycle after T through the cycle containing edge T+MUL_LATENCY.
  - Divide: high from the cycle after T through the cycle containing edge T+33.
- done: high for exactly the one cycle following the HI/LO write edge of a MUL/DIV.
- stall_req = (busy & ex_op != NONE) | (id_reads_hilo & (busy | start & ex_op in 1..4)).
  - Combinational; covers back-to-back MFHI after MULT/DIV.
  - MTHI/MTLO in EX with MFHI/MFLO in ID does not stall; the write lands at edge T, before MF reaches EX.
- A new op in EX while busy is held by stall_req and starts on the first edge where busy = 0.
  - The held op starts no earlier than the edge after the completion write.
- ex_flush is ignored while busy; in-flight operations are never aborted except by reset.
- hi/lo change only at the write edges defined above.

Test Plan:
- MULT rs=-5 (0xFFFFFFFB), rt=3, MUL_LATENCY=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 after edge T+2; busy high for 2 cycles; done pulse on the next cycle.
- DIVU 100/7 -> lo=14, hi=2 written at edge T+33; busy high for 33 cycles; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234 at T+33; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT in EX with MFLO in ID on the same cycle -> stall_req=1 immediately and held until the write; MFLO then reads the product. MTLO 0xABCD with MFLO in ID -> no stall; lo=0xABCD.
- DIV in flight and MTHI arrives in EX -> stall_req=1 and hi unchanged until the divide completes; MTHI is applied on the first non-busy edge.
- reset_n asserted at iteration 10 of a DIV -> immediately busy=0, hi=lo=0, state IDLE; a MULT 6*7 after release gives lo=42, hi=0.
